// File: rtl/ab_symbol_tx.sv
// ab_symbol_tx: serializes a latched word into timed 2-bit symbols on a/b
// for the fsm pattern recognizer, with a start / busy / done host handshake.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high reset
//   start  - frame request, sampled only in IDLE
//   data   - frame payload, symbol i = data[2i+1:2i] (bit 1 -> a, bit 0 -> b)
//   len    - symbols to send, clamped to MAX_SYMS
//   a, b   - registered symbol bits toward fsm
//   busy   - registered, high for the whole frame including the GAP cycle
//   done   - registered one-cycle end-of-frame pulse
module ab_symbol_tx #(
    parameter int unsigned MAX_SYMS = 8,
    parameter int unsigned SYM_HOLD = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [2*MAX_SYMS-1:0]         data,
    input  logic [$clog2(MAX_SYMS+1)-1:0] len,
    output logic                          a,
    output logic                          b,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned DW = 2 * MAX_SYMS;
    localparam int unsigned LW = $clog2(MAX_SYMS + 1);
    localparam int unsigned IW = (MAX_SYMS > 1) ? $clog2(MAX_SYMS) : 1;
    localparam int unsigned HW = $clog2(SYM_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   data_q;
    logic [LW-1:0]   len_q;
    logic [IW-1:0]   idx;
    logic [HW-1:0]   hold;

    logic [LW-1:0]   len_clamp_c;
    logic            hold_last_c;
    logic            idx_last_c;
    logic [1:0]      sym_c;
    logic            a_nxt;
    logic            b_nxt;
    logic            busy_nxt;
    logic            done_nxt;

    // Unsigned clamp of the requested length.
    assign len_clamp_c = (len > LW'(MAX_SYMS)) ? LW'(MAX_SYMS) : len;

    assign hold_last_c = (hold == HW'(SYM_HOLD - 1));
    assign idx_last_c  = (LW'(idx) == (len_q - LW'(1)));
    assign sym_c       = 2'(data_q >> {idx, 1'b0});

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len_clamp_c != '0) ? SEND : GAP;
                end
            end
            SEND: begin
                if (hold_last_c && idx_last_c) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode of the current state; registered below, so a/b/busy/done
    // trail the state by one cycle.
    always_comb begin
        a_nxt    = 1'b0;
        b_nxt    = 1'b0;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        unique case (state)
            SEND: begin
                a_nxt    = sym_c[1];
                b_nxt    = sym_c[0];
                busy_nxt = 1'b1;
            end
            GAP: begin
                busy_nxt = 1'b1;
                done_nxt = 1'b1;
            end
            default: begin
                a_nxt    = 1'b0;
            end
        endcase
    end

    // Frame latch, symbol index / hold counter, and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            len_q  <= '0;
            idx    <= '0;
            hold   <= '0;
            a      <= 1'b0;
            b      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            a    <= a_nxt;
            b    <= b_nxt;
            busy <= busy_nxt;
            done <= done_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        data_q <= data;
                        len_q  <= len_clamp_c;
                        idx    <= '0;
                        hold   <= '0;
                    end
                end
                SEND: begin
                    if (hold_last_c) begin
                        hold <= '0;
                        // Index stays on the last symbol rather than wrapping.
                        if (!idx_last_c) begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                default: begin
                    hold <= hold;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ab_symbol_tx.sv
module tb_ab_symbol_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  len = '0;
    logic        a0, b0, busy0, done0;
    logic        a1, b1, busy1, done1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Expected {a,b,busy,done} per clock edge for each instance
    // (inst 0: SYM_HOLD=2, inst 1: SYM_HOLD=1).
    logic [3:0] sched [2][0:4095];
    int         ready [2];

    ab_symbol_tx #(.MAX_SYMS(8), .SYM_HOLD(2)) u_h2 (
        .clk(clk), .reset(reset), .start(start), .data(data), .len(len),
        .a(a0), .b(b0), .busy(busy0), .done(done0)
    );

    ab_symbol_tx #(.MAX_SYMS(8), .SYM_HOLD(1)) u_h1 (
        .clk(clk), .reset(reset), .start(start), .data(data), .len(len),
        .a(a1), .b(b1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] obs(input int i);
        return (i == 0) ? {a0, b0, busy0, done0} : {a1, b1, busy1, done1};
    endfunction

    // Frame-level reference: an accepted start at edge t schedules symbol k
    // on edges t+1+k*H .. t+(k+1)*H, the done cycle on t+1+N*H, and the next
    // possible acceptance at t+N*H+2.
    task automatic model_edge();
        int h;
        int n;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            h = (i == 0) ? 2 : 1;
            if (reset) begin
                for (int t = cyc; t < cyc + 64 && t < 4096; t++) sched[i][t] = 4'b0000;
                ready[i] = cyc + 1;
            end else if (start && cyc >= ready[i]) begin
                n = (len > 4'd8) ? 8 : int'(len);
                for (int k = 0; k < n; k++)
                    for (int hh = 0; hh < h; hh++)
                        sched[i][cyc + 1 + k*h + hh] = {data[2*k+1], data[2*k], 2'b10};
                sched[i][cyc + 1 + n*h] = 4'b0011;
                ready[i] = cyc + n*h + 2;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== 4'b0000) begin
                    failures++;
                    $display("FAIL reset_idle inst=%0d cyc=%0d got=%b exp=0000", i, cyc, obs(i));
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        start = 1'b0;
        for (int j = 0; j < n; j++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== sched[i][cyc]) begin
                    failures++;
                    $display("FAIL idle_model inst=%0d cyc=%0d got=%b exp=%b", i, cyc, obs(i), sched[i][cyc]);
                end
            end
        end
    endtask

    task automatic test_basic();
        logic [1:0] tbl [8];
        tbl = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
        data  = 16'h00E4;
        len   = 4'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        data  = 16'($urandom);
        len   = 4'($urandom_range(0, 15));
        checks++;
        if (obs(0) !== 4'b0000) begin
            failures++;
            $display("FAIL basic_latency got=%b exp=0000", obs(0));
        end
        for (int j = 0; j < 8; j++) begin
            tick();
            checks++;
            if (obs(0) !== {tbl[j], 2'b10}) begin
                failures++;
                $display("FAIL basic_sym j=%0d got=%b exp=%b", j, obs(0), {tbl[j], 2'b10});
            end
            checks++;
            if (obs(1) !== sched[1][cyc]) begin
                failures++;
                $display("FAIL basic_model_h1 cyc=%0d got=%b exp=%b", cyc, obs(1), sched[1][cyc]);
            end
        end
        tick();
        checks++;
        if (obs(0) !== 4'b0011) begin
            failures++;
            $display("FAIL basic_gap got=%b exp=0011", obs(0));
        end
        tick();
        checks++;
        if (obs(0) !== 4'b0000) begin
            failures++;
            $display("FAIL basic_after got=%b exp=0000", obs(0));
        end
    endtask

    task automatic test_zero_len();
        len   = 4'd0;
        data  = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== 4'b0000) begin
                failures++;
                $display("FAIL zero_t1 inst=%0d got=%b exp=0000", i, obs(i));
            end
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== 4'b0011) begin
                failures++;
                $display("FAIL zero_gap inst=%0d got=%b exp=0011", i, obs(i));
            end
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== 4'b0000) begin
                failures++;
                $display("FAIL zero_after inst=%0d got=%b exp=0000", i, obs(i));
            end
        end
    endtask

    task automatic test_clamp_ignored_start();
        int n11 = 0;
        int ndone = 0;
        data  = 16'hFFFF;
        len   = 4'd15;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 14; j++) begin
            start = (j == 3);
            tick();
            if (obs(1) == 4'b1110) n11++;
            if (done1) ndone++;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== sched[i][cyc]) begin
                    failures++;
                    $display("FAIL clamp_model inst=%0d cyc=%0d got=%b exp=%b", i, cyc, obs(i), sched[i][cyc]);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (n11 !== 8) begin
            failures++;
            $display("FAIL clamp_sym_count got=%0d exp=8", n11);
        end
        checks++;
        if (ndone !== 1) begin
            failures++;
            $display("FAIL clamp_done_count got=%0d exp=1", ndone);
        end
    endtask

    task automatic test_reset_mid_frame();
        int ndone = 0;
        logic [3:0] seq [4];
        seq = '{4'b1110, 4'b1010, 4'b0110, 4'b0011};
        data  = 16'h001B;
        len   = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (obs(1) !== 4'b1010) begin
            failures++;
            $display("FAIL midrst_sym1 got=%b exp=1010", obs(1));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== 4'b0000) begin
                failures++;
                $display("FAIL midrst_clear inst=%0d got=%b exp=0000", i, obs(i));
            end
        end
        for (int j = 0; j < 10; j++) begin
            tick();
            if (done0 || done1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL midrst_no_done got=%0d exp=0", ndone);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (obs(1) !== seq[j]) begin
                failures++;
                $display("FAIL midrst_resend j=%0d got=%b exp=%b", j, obs(1), seq[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int waited = 0;
        data  = 16'($urandom);
        len   = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!done1 && waited < 40) begin
            tick();
            waited++;
        end
        checks++;
        if (done1 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_wait_done got=%b exp=1", done1);
        end
        // Request the next frame while the done cycle is showing.
        data  = 16'h0003;
        len   = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (obs(1) !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_separator got=%b exp=0000", obs(1));
        end
        tick();
        checks++;
        if (obs(1) !== 4'b1110) begin
            failures++;
            $display("FAIL b2b_sym0 got=%b exp=1110", obs(1));
        end
        checks++;
        if (obs(0) !== sched[0][cyc]) begin
            failures++;
            $display("FAIL b2b_model_h2 cyc=%0d got=%b exp=%b", cyc, obs(0), sched[0][cyc]);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            start = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 63) == 0);
            data  = 16'($urandom);
            len   = 4'($urandom_range(0, 15));
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== sched[i][cyc]) begin
                    failures++;
                    $display("FAIL rand_model inst=%0d cyc=%0d got=%b exp=%b", i, cyc, obs(i), sched[i][cyc]);
                end
            end
        end
        reset = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            ready[i] = 0;
            for (int t = 0; t < 4096; t++) sched[i][t] = 4'b0000;
        end
        #1;
        test_reset();
        test_basic();
        idle_cycles(25);
        test_zero_len();
        idle_cycles(5);
        test_clamp_ignored_start();
        idle_cycles(25);
        test_reset_mid_frame();
        idle_cycles(25);
        test_back_to_back();
        idle_cycles(25);
        test_random();
        idle_cycles(25);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
